wm_cycle_ctrl: RTL

//  Parametrised washing-machine cycle controller: coin credit, N wash programmes, per-programme stage times,

---
 rtl/wm_pkg.sv | 40 ++++
 rtl/wm_stage_timer.sv | 64 ++++++
 rtl/wm_cycle_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine cycle controller.
// Holds the o_state bit positions, the one-hot state constants and the state enum used by
// wm_cycle_ctrl, plus masks that group states by the actuators they drive.
package wm_pkg;

  localparam int unsigned STATE_W = 7;

  // Bit positions inside o_state.
  localparam int unsigned S_IDLE  = 0;
  localparam int unsigned S_READY = 1;
  localparam int unsigned S_SOAK  = 2;
  localparam int unsigned S_WASH  = 3;
  localparam int unsigned S_RINSE = 4;
  localparam int unsigned S_DRAIN = 5;
  localparam int unsigned S_SPIN  = 6;

  localparam logic [STATE_W-1:0] OH_IDLE  = 7'b000_0001;
  localparam logic [STATE_W-1:0] OH_READY = 7'b000_0010;
  localparam logic [STATE_W-1:0] OH_SOAK  = 7'b000_0100;
  localparam logic [STATE_W-1:0] OH_WASH  = 7'b000_1000;
  localparam logic [STATE_W-1:0] OH_RINSE = 7'b001_0000;
  localparam logic [STATE_W-1:0] OH_DRAIN = 7'b010_0000;
  localparam logic [STATE_W-1:0] OH_SPIN  = 7'b100_0000;

  // States in which a stage timer runs.
  localparam logic [STATE_W-1:0] RUN_MASK = OH_SOAK | OH_WASH | OH_RINSE | OH_DRAIN | OH_SPIN;
  // States that fill the drum.
  localparam logic [STATE_W-1:0] WET_MASK = OH_SOAK | OH_WASH | OH_RINSE;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = OH_IDLE,
    StReady = OH_READY,
    StSoak  = OH_SOAK,
    StWash  = OH_WASH,
    StRinse = OH_RINSE,
    StDrain = OH_DRAIN,
    StSpin  = OH_SPIN
  } wm_state_e;

endpackage

// File: rtl/wm_stage_timer.sv
// Stage timer: prescaler dividing the clock down to 1 s ticks, feeding a down-counter of
// seconds left in the current stage.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        force counter and prescaler to 0 (highest priority)
//   load_i         load load_val_i into the counter, restart the prescaler
//   load_val_i     seconds for the stage being entered
//   run_i          advance the prescaler this cycle (low = frozen, e.g. lid open)
//   remaining_o    seconds left in the stage
//   expire_o       final tick of the stage (tick with remaining_o == 1)
module wm_stage_timer #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned TIME_W   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [TIME_W-1:0] load_val_i,
  input  logic              run_i,
  output logic [TIME_W-1:0] remaining_o,
  output logic              expire_o
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  logic [PreW-1:0]   pre_q, pre_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic              tick;

  assign tick     = run_i && (pre_q == PreMax);
  assign expire_o = tick && (rem_q == TIME_W'(1));

  always_comb begin
    pre_d = pre_q;
    rem_d = rem_q;
    if (clear_i) begin
      pre_d = '0;
      rem_d = '0;
    end else if (load_i) begin
      pre_d = '0;
      rem_d = load_val_i;
    end else if (tick) begin
      pre_d = '0;
      rem_d = rem_q - TIME_W'(1);
    end else if (run_i) begin
      pre_d = pre_q + PreW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q <= '0;
      rem_q <= '0;
    end else begin
      pre_q <= pre_d;
      rem_q <= rem_d;
    end
  end

  assign remaining_o = rem_q;

endmodule

// File: rtl/wm_cycle_ctrl.sv
// Washing-machine cycle controller: coin credit, NUM_MODES programmes with per-programme stage
// time, repeated rinse passes, lid pause with exact resume, cancel/refund.
// Build option: define WM_DRAIN_EN to insert a DRAIN stage (DRAIN_T s) between the last rinse
// and SPIN; without it the DRAIN bit of o_state and o_drain are tied 0.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_coin                       coin sensor level, each rising edge adds one credit
//   i_lid                        1 = lid open (pauses a running stage)
//   i_start, i_cancel            panel requests
//   i_mode                       programme index
//   o_state                      one-hot state (bit order in wm_pkg)
//   o_waterinlet, o_drain        actuators, dropped while paused
//   o_paused                     running stage held by open lid
//   o_remaining                  seconds left in stage, 0 outside running stages
//   o_rinse_pass                 1-based rinse pass, 0 outside RINSE
//   o_credits                    saturating credit count
//   o_coinreturn, o_done         one-cycle pulses: refund, cycle complete
module wm_cycle_ctrl
  import wm_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned NUM_MODES  = 3,
  parameter int unsigned TIME_W     = 10,
  parameter logic [NUM_MODES*TIME_W-1:0] MODE_TIMES = {10'd5, 10'd3, 10'd1},
  parameter int unsigned RINSE_REPS = 1,
  parameter int unsigned COIN_PRICE = 1,
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned DRAIN_T    = 2,
  localparam int unsigned MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_coin,
  input  logic                i_lid,
  input  logic                i_start,
  input  logic                i_cancel,
  input  logic [MODE_W-1:0]   i_mode,
  output logic [STATE_W-1:0]  o_state,
  output logic                o_waterinlet,
  output logic                o_drain,
  output logic                o_paused,
  output logic [TIME_W-1:0]   o_remaining,
  output logic [3:0]          o_rinse_pass,
  output logic [CREDIT_W-1:0] o_credits,
  output logic                o_coinreturn,
  output logic                o_done
);

  localparam logic [CREDIT_W-1:0] MaxCredit = {CREDIT_W{1'b1}};
  localparam logic [CREDIT_W:0]   PriceW    = (CREDIT_W + 1)'(COIN_PRICE);
  localparam logic [TIME_W-1:0]   DrainTime = (DRAIN_T == 0) ? TIME_W'(1) : TIME_W'(DRAIN_T);

  // Stage seconds for a programme; a zero entry is treated as one second.
  function automatic logic [TIME_W-1:0] mode_time(input logic [MODE_W-1:0] m);
    logic [TIME_W-1:0] t;
    t = MODE_TIMES[32'(m) * TIME_W +: TIME_W];
    return (t == '0) ? TIME_W'(1) : t;
  endfunction

  wm_state_e           state_q, state_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [3:0]          pass_q, pass_d;
  logic                coin_q;
  logic                done_q, done_d;
  logic                refund_q, refund_d;

  logic                coin_rise, credit_ok, mode_ok, running, consume, drop;
  logic                tmr_load, tmr_clear, expire;
  logic [TIME_W-1:0]   tmr_val, remaining;
  logic [CREDIT_W:0]   credit_sum;

  assign coin_rise = i_coin & ~coin_q;
  assign credit_ok = 32'(credits_q) >= COIN_PRICE;
  assign mode_ok   = 32'(i_mode) < NUM_MODES;
  assign running   = |(state_q & RUN_MASK);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    refund_d  = 1'b0;
    consume   = 1'b0;
    drop      = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (credit_ok && !i_lid) state_d = StReady;
      end
      StReady: begin
        if (i_cancel) begin
          state_d  = StIdle;
          refund_d = 1'b1;
          drop     = 1'b1;
        end else if (!credit_ok) begin
          state_d = StIdle;
        end else if (i_start && !i_lid && mode_ok) begin
          state_d  = StSoak;
          mode_d   = i_mode;
          consume  = 1'b1;
          tmr_load = 1'b1;
        end
      end
      default: begin
        // Cancel outranks lid pause and stage completion.
        if (i_cancel) begin
          state_d   = StIdle;
          mode_d    = '0;
          pass_d    = '0;
          tmr_clear = 1'b1;
        end else if (expire) begin
          tmr_load = 1'b1;
          unique case (state_q)
            StSoak: state_d = StWash;
            StWash: begin
              state_d = StRinse;
              pass_d  = 4'd1;
            end
            StRinse: begin
              if (32'(pass_q) < RINSE_REPS) begin
                pass_d = pass_q + 4'd1;
              end else begin
                pass_d = '0;
`ifdef WM_DRAIN_EN
                state_d = StDrain;
`else
                state_d = StSpin;
`endif
              end
            end
            StDrain: state_d = StSpin;
            StSpin: begin
              state_d   = StIdle;
              mode_d    = '0;
              done_d    = 1'b1;
              tmr_load  = 1'b0;
              tmr_clear = 1'b1;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // The value loaded follows the state being entered; on READY->SOAK mode_d is the new mode.
  assign tmr_val = (state_d == StDrain) ? DrainTime : mode_time(mode_d);

  // Coin accepted in the same cycle as a start still counts; a refund drops it.
  always_comb begin
    credit_sum = {1'b0, credits_q} + {{CREDIT_W{1'b0}}, coin_rise};
    if (consume) credit_sum = credit_sum - PriceW;
    if (drop) begin
      credits_d = '0;
    end else if (credit_sum > {1'b0, MaxCredit}) begin
      credits_d = MaxCredit;
    end else begin
      credits_d = credit_sum[CREDIT_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      credits_q <= '0;
      mode_q    <= '0;
      pass_q    <= '0;
      coin_q    <= 1'b0;
      done_q    <= 1'b0;
      refund_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      mode_q    <= mode_d;
      pass_q    <= pass_d;
      coin_q    <= i_coin;
      done_q    <= done_d;
      refund_q  <= refund_d;
    end
  end

  wm_stage_timer #(
    .TICK_DIV (TICK_DIV),
    .TIME_W   (TIME_W)
  ) u_timer (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .clear_i     (tmr_clear),
    .load_i      (tmr_load),
    .load_val_i  (tmr_val),
    .run_i       (running && !i_lid),
    .remaining_o (remaining),
    .expire_o    (expire)
  );

  assign o_paused     = running & i_lid;
  assign o_waterinlet = (|(state_q & WET_MASK)) & ~i_lid;
`ifdef WM_DRAIN_EN
  assign o_state      = state_q;
  assign o_drain      = (state_q == StDrain) & ~i_lid;
`else
  assign o_state      = state_q & ~OH_DRAIN;
  assign o_drain      = 1'b0;
`endif
  assign o_remaining  = remaining;
  assign o_rinse_pass = pass_q;
  assign o_credits    = credits_q;
  assign o_coinreturn = refund_q;
  assign o_done       = done_q;

endmodule
